// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_multi
//  Description : N-channel push-button conditioner. Each channel has a 2-flop
//                synchroniser, a stability counter, and a hold counter. It
//                produces a debounced level, press/release/long-press pulses,
//                and a toggle output.
//  Revision    : 1.0 - initial parameterised release
// ============================================================================
module key_debounce_multi #(
  parameter int NUM_KEYS          = 3,
  parameter int DEB_CYCLES        = 1000000,
  parameter int LONG_CYCLES       = 100000000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter bit TOGGLE_ON_RELEASE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] toggle
);

  localparam int                  C_DEB_W     = $clog2(DEB_CYCLES);
  localparam int                  C_HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [C_DEB_W-1:0]  C_DEB_MAX   = C_DEB_W'(DEB_CYCLES - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(LONG_CYCLES);
  localparam logic [C_HOLD_W-1:0] C_HOLD_PRE  = C_HOLD_W'(LONG_CYCLES - 1);
  // Raw level of an idle (released) key
  localparam logic                C_RELEASED  = ACTIVE_LOW;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    logic                r_sync1;
    logic                r_sync2;
    logic                r_key_state;
    logic                r_press_pulse;
    logic                r_release_pulse;
    logic                r_long_pulse;
    logic                r_long_seen;
    logic                r_toggle;
    logic [C_DEB_W-1:0]  r_deb_cnt;
    logic [C_HOLD_W-1:0] r_hold_cnt;
    logic                w_pressed;
    logic                w_toggle_evt;

    // Normalise polarity so everything downstream is pressed = 1
    assign w_pressed = r_sync2 ^ C_RELEASED;

    // A long press suppresses the release toggle; the long pulse itself is
    // included so a release accepted on the very edge the hold limit is
    // reached still counts as long
    assign w_toggle_evt = TOGGLE_ON_RELEASE
                          ? (r_release_pulse & ~(r_long_seen | r_long_pulse))
                          : r_press_pulse;

    // Two-flop synchroniser, reset to the idle raw level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= C_RELEASED;
        r_sync2 <= C_RELEASED;
      end else begin
        r_sync1 <= key_in[g];
        r_sync2 <= r_sync1;
      end
    end

    // Stability qualification: a new level must persist DEB_CYCLES edges
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_deb_cnt       <= '0;
        r_key_state     <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
      end else begin
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
        if (w_pressed == r_key_state) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == C_DEB_MAX) begin
          r_deb_cnt       <= '0;
          r_key_state     <= w_pressed;
          r_press_pulse   <= w_pressed;
          r_release_pulse <= ~w_pressed;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
    end

    // Saturating hold counter; single long pulse per press
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold_cnt   <= '0;
        r_long_pulse <= 1'b0;
      end else begin
        r_long_pulse <= r_key_state && (r_hold_cnt == C_HOLD_PRE);
        if (!r_key_state) begin
          r_hold_cnt <= '0;
        end else if (r_hold_cnt != C_HOLD_MAX) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end

    // Long-press memory and toggle flip-flop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_long_seen <= 1'b0;
        r_toggle    <= 1'b0;
      end else begin
        if (r_release_pulse) begin
          r_long_seen <= 1'b0;
        end else if (r_long_pulse) begin
          r_long_seen <= 1'b1;
        end
        if (w_toggle_evt) begin
          r_toggle <= ~r_toggle;
        end
      end
    end

    assign key_state[g]     = r_key_state;
    assign press_pulse[g]   = r_press_pulse;
    assign release_pulse[g] = r_release_pulse;
    assign long_pulse[g]    = r_long_pulse;
    assign toggle[g]        = r_toggle;
  end : g_chan

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce_multi
//  Description : Self-checking bench for key_debounce_multi. Two instances:
//                active-low/toggle-on-release and active-high/toggle-on-press,
//                driven with logically identical key activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

  localparam int DEB  = 8;
  localparam int LONG = 32;

  logic       clk;
  logic       rst_n;
  logic [2:0] key_in;
  logic [2:0] key_in_m;
  logic [2:0] ks, pp, rp, lp, tg;
  logic [2:0] ks_m, pp_m, rp_m, lp_m, tg_m;

  assign key_in_m = ~key_in;

  key_debounce_multi #(
    .NUM_KEYS(3), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .ACTIVE_LOW(1'b1), .TOGGLE_ON_RELEASE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_state(ks), .press_pulse(pp), .release_pulse(rp),
    .long_pulse(lp), .toggle(tg)
  );

  key_debounce_multi #(
    .NUM_KEYS(3), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
    .ACTIVE_LOW(1'b0), .TOGGLE_ON_RELEASE(1'b0)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_m),
    .key_state(ks_m), .press_pulse(pp_m), .release_pulse(rp_m),
    .long_pulse(lp_m), .toggle(tg_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int n_steps  = 0;

  // ---------------- reference model ----------------
  // Each channel keeps the recent history of pressed samples; a level is
  // accepted once the DEB samples visible past the synchroniser all disagree
  // with the current debounced level.
  logic [DEB+1:0] hv [3];
  logic           st [3];
  int             pedge [3];
  logic           longp [3];
  logic           rel_long [3];
  logic [2:0]     e_ks, e_pp, e_rp, e_lp, e_tr, e_tp;
  int             cyc = 0;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      hv[c] = '0; st[c] = 1'b0; pedge[c] = 0;
      longp[c] = 1'b0; rel_long[c] = 1'b0;
    end
    e_ks = '0; e_pp = '0; e_rp = '0; e_lp = '0; e_tr = '0; e_tp = '0;
  endtask

  task automatic model_edge(input logic [2:0] pressed);
    logic [2:0] prev_pp, prev_rp;
    logic       acc;
    prev_pp = e_pp;
    prev_rp = e_rp;
    cyc++;
    for (int c = 0; c < 3; c++) begin
      hv[c] = {hv[c][DEB:0], pressed[c]};
      acc = 1'b1;
      for (int i = 2; i <= DEB + 1; i++)
        if (hv[c][i] == st[c]) acc = 1'b0;
      if (prev_rp[c] && !rel_long[c]) e_tr[c] = ~e_tr[c];
      if (prev_pp[c]) e_tp[c] = ~e_tp[c];
      e_lp[c] = st[c] && ((cyc - pedge[c]) == LONG);
      if (e_lp[c]) longp[c] = 1'b1;
      e_pp[c] = acc && !st[c];
      e_rp[c] = acc && st[c];
      if (e_rp[c]) begin
        rel_long[c] = longp[c];
        longp[c] = 1'b0;
      end
      if (acc) begin
        st[c] = ~st[c];
        if (st[c]) pedge[c] = cyc;
      end
      e_ks[c] = st[c];
    end
  endtask

  task automatic check_model();
    n_checks++;
    if ({ks, pp, rp, lp, tg} !== {e_ks, e_pp, e_rp, e_lp, e_tr}) begin
      n_fails++;
      $display("FAIL model_rel step=%0d got ks=%b pp=%b rp=%b lp=%b tg=%b want ks=%b pp=%b rp=%b lp=%b tg=%b",
               n_steps, ks, pp, rp, lp, tg, e_ks, e_pp, e_rp, e_lp, e_tr);
    end
    n_checks++;
    if ({ks_m, pp_m, rp_m, lp_m, tg_m} !== {e_ks, e_pp, e_rp, e_lp, e_tp}) begin
      n_fails++;
      $display("FAIL model_press step=%0d got ks=%b pp=%b rp=%b lp=%b tg=%b want ks=%b pp=%b rp=%b lp=%b tg=%b",
               n_steps, ks_m, pp_m, rp_m, lp_m, tg_m, e_ks, e_pp, e_rp, e_lp, e_tp);
    end
  endtask

  // Drive one clock of raw keys (called at a falling edge), update the model
  // on the rising edge and compare on the next falling edge.
  task automatic step(input logic [2:0] k);
    key_in = k;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(~k);
    @(negedge clk);
    n_steps++;
    check_model();
  endtask

  task automatic check_const(input string name, input logic [17:0] got,
                             input logic [17:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s got ks=%b pp=%b rp=%b lp=%b tg=%b tgm=%b want ks=%b pp=%b rp=%b lp=%b tg=%b tgm=%b",
               name, got[17:15], got[14:12], got[11:9], got[8:6], got[5:3], got[2:0],
               want[17:15], want[14:12], want[11:9], want[8:6], want[5:3], want[2:0]);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] keys;
    int         n;
    logic [2:0] ks, pp, rp, lp, tg, tm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] keys, input int n,
                              input logic [2:0] eks, input logic [2:0] epp,
                              input logic [2:0] erp, input logic [2:0] elp,
                              input logic [2:0] etg, input logic [2:0] etm);
    vec_t v;
    v.keys = keys; v.n = n; v.ks = eks; v.pp = epp;
    v.rp = erp; v.lp = elp; v.tg = etg; v.tm = etm;
    return v;
  endfunction

  logic [2:0] raw;
  int         cnt [3];

  initial begin
    // Reset / idle
    vecs.push_back(mk(3'b111, 20, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
    // Bounce rejection on key 0
    vecs.push_back(mk(3'b110,  5, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(3'b110,  6, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(3'b111, 12, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
    // Clean press/release on key 0
    vecs.push_back(mk(3'b110,  9, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000));
    vecs.push_back(mk(3'b110,  5, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
    vecs.push_back(mk(3'b111,  9, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
    vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001));
    vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001));
    // Long press on key 1
    vecs.push_back(mk(3'b101, 10, 3'b010, 3'b010, 3'b000, 3'b000, 3'b001, 3'b001));
    vecs.push_back(mk(3'b101, 31, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b011));
    vecs.push_back(mk(3'b101,  1, 3'b010, 3'b000, 3'b000, 3'b010, 3'b001, 3'b011));
    vecs.push_back(mk(3'b101,  1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b011));
    vecs.push_back(mk(3'b101, 27, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b011));
    vecs.push_back(mk(3'b111, 10, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b011));
    vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b011));
    // Simultaneous keys
    vecs.push_back(mk(3'b000, 10, 3'b111, 3'b111, 3'b000, 3'b000, 3'b001, 3'b011));
    vecs.push_back(mk(3'b100, 10, 3'b011, 3'b000, 3'b100, 3'b000, 3'b001, 3'b100));
    vecs.push_back(mk(3'b100,  1, 3'b011, 3'b000, 3'b000, 3'b000, 3'b101, 3'b100));
    vecs.push_back(mk(3'b111, 10, 3'b000, 3'b000, 3'b011, 3'b000, 3'b101, 3'b100));
    vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b100));

    rst_n  = 1'b0;
    key_in = 3'b111;
    model_reset();
    repeat (3) @(negedge clk);
    check_const("reset_hold", {ks, pp, rp, lp, tg, tg_m}, 18'd0);
    rst_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      for (int j = 0; j < vecs[v].n; j++) step(vecs[v].keys);
      check_const($sformatf("vec%0d", v), {ks, pp, rp, lp, tg, tg_m},
                  {vecs[v].ks, vecs[v].pp, vecs[v].rp, vecs[v].lp, vecs[v].tg, vecs[v].tm});
    end

    // Reset in the middle of qualifying key 2, key still held afterwards
    repeat (5) step(3'b011);
    rst_n = 1'b0;
    #1;
    check_const("async_reset", {ks, pp, rp, lp, tg, tg_m}, 18'd0);
    step(3'b011);
    step(3'b011);
    rst_n = 1'b1;
    repeat (9) step(3'b011);
    check_const("requal_9", {ks, pp, rp, lp, tg, tg_m}, 18'd0);
    step(3'b011);
    check_const("requal_10", {ks, pp, rp, lp, tg, tg_m},
                {3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000});
    step(3'b011);
    check_const("requal_11", {ks, pp, rp, lp, tg, tg_m},
                {3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100});
    repeat (12) step(3'b111);

    // Randomised bouncing keys against the model, with one reset inside
    raw = 3'b111;
    for (int c = 0; c < 3; c++) cnt[c] = $urandom_range(1, 20);
    for (int s = 0; s < 4000; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (cnt[c] == 0) begin
          raw[c] = ~raw[c];
          cnt[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 70)
                                               : $urandom_range(1, 10);
        end else begin
          cnt[c]--;
        end
      end
      if (s == 2000) rst_n = 1'b0;
      if (s == 2003) rst_n = 1'b1;
      step(raw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parameterised N-channel push-button conditioner and the successor to the fixed 3-key debounce/toggle block. Each key channel has its own input synchroniser, a stability counter, and a hold-time counter. Per channel it produces a debounced level, single-cycle press and release pulses, a long-press pulse, and a toggle output. It sits between raw board buttons and the user-interface/LED control logic.

Parameters:
NUM_KEYS, 3, number of independent key channels (>=1)
DEB_CYCLES, 1000000, clocks the synchronised input must remain stable before it is accepted (20 ms @ 50 MHz; >=2)
LONG_CYCLES, 100000000, clocks key_state must remain pressed to raise long_pulse (2 s @ 50 MHz; >=2)
ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
TOGGLE_ON_RELEASE, 1, 1: toggle flips on release; 0: toggle flips on press

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_in  input  NUM_KEYS  raw, asynchronous button inputs; polarity set by ACTIVE_LOW
key_state  output  NUM_KEYS  debounced level, 1 = pressed
press_pulse  output  NUM_KEYS  one-clk pulse on an accepted press
release_pulse  output  NUM_KEYS  one-clk pulse on an accepted release
long_pulse  output  NUM_KEYS  one-clk pulse when a press reaches LONG_CYCLES
toggle  output  NUM_KEYS  per-channel toggled state

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk. All state is in flops reset by rst_n.
- Reset values:
  - Synchroniser flops = released raw level (1 when ACTIVE_LOW=1, else 0).
  - key_state = 0; press_pulse, release_pulse, long_pulse = 0; toggle = 0.
  - All counters = 0; long_seen = 0.
- Polarity: raw input is normalised to pressed=1 after the 2-flop synchroniser (sync2). All further logic is active-high.
- Stability counter (width $clog2(DEB_CYCLES)), per channel:
  - If sync2 == key_state: counter cleared to 0.
  - If sync2 != key_state and counter < DEB_CYCLES-1: counter increments.
  - If sync2 != key_state and counter == DEB_CYCLES-1: key_state <= sync2 and counter <= 0.
  - Consequence: any bounce back to the stable level restarts qualification. No transition is accepted on partial stability.
- Latency: key_state changes on the (DEB_CYCLES+2)th rising edge after the raw input settles, counted from the first edge that samples the new value.
- Pulses are registered and high for exactly one cycle.
  - press_pulse is high in the first cycle key_state reads 1.
  - release_pulse is high in the first cycle key_state reads 0.
  - A channel never asserts press_pulse and release_pulse in the same cycle.
- Hold counter (width $clog2(LONG_CYCLES+1)):
  - Cleared while key_state=0.
  - Increments while key_state=1, saturating at LONG_CYCLES.
  - long_pulse is high for one cycle when the counter steps from LONG_CYCLES-1 to LONG_CYCLES, i.e. LONG_CYCLES cycles after press_pulse.
  - At most one long_pulse per press. No auto-repeat.
- long_seen: set with long_pulse, cleared with release_pulse.
- Toggle:
  - TOGGLE_ON_RELEASE=1: toggle flips in the cycle after release_pulse, but only if long_seen was 0 at that release. A long press never toggles.
  - TOGGLE_ON_RELEASE=0: toggle flips in the cycle after press_pulse; long_seen has no effect.
- Channel independence: channels share no state. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-operation: all counters, pulses, toggle, and long_seen return to reset values immediately. A key still held when reset releases must re-qualify for DEB_CYCLES before press_pulse.
- Counter widths are fixed per parameter. Counters never wrap; the stability counter is bounded by DEB_CYCLES-1 and the hold counter saturates.

Test Plan:
Unless stated, the bench uses NUM_KEYS=3, DEB_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1, TOGGLE_ON_RELEASE=1.
1. Reset: assert rst_n=0 with key_in=3'b111, then release -> all outputs 0 for 20 cycles.
2. Bounce rejection: key_in[0] low 5 cycles, high 3, low 6, then high -> key_state[0] stays 0 and no pulses.
3. Clean press: key_in[0] driven low and held -> key_state[0]=1 and press_pulse[0]=1 on the 10th edge; release -> release_pulse[0] 10 edges later; toggle[0] flips 0->1 on the following edge.
4. Long press: hold key_in[1] low 60 cycles after acceptance -> exactly one long_pulse[1], 32 cycles after press_pulse[1]; on release toggle[1] stays 0.
5. Simultaneous keys: key_in=3'b000 at the same edge -> press_pulse=3'b111 in one cycle; release key2 only -> release_pulse=3'b100 only.
6. Reset mid-count: key_in[2] low 5 cycles, then rst_n pulse while still low -> no press; press_pulse[2] arrives 10 edges after rst_n release.
7. Mode: TOGGLE_ON_RELEASE=0, ACTIVE_LOW=0 -> raw 1 pressed; toggle flips the edge after press_pulse, including on long presses.
